mem_stage_multicycle: RTL and testbench
=======================================

// Module: mem_stage_multicycle
// PURPOSE
//  Parametrised MEM pipeline stage with a multi-cycle data memory. A load or store
//  stalls the pipeline for LATENCY cycles by raising freeze to the upstream stages
//  (IF/ID/EX and the EX/MEM register), then releases one completed result toward MEM/WB.
//  Non-memory instructions pass through combinationally with zero added latency.
// PARAMETERS
//  DATA_W     32    data word width in bits; must be a multiple of 8
//  ADDR_W     32    address width in bits
//  DEPTH      64    number of DATA_W words in the internal memory array
//  LATENCY    4     stall cycles per memory access; legal values are >= 1
//  BASE_ADDR  1024  byte address that maps to word 0
// PORTS
//  clk             in   1       clock; every register updates on the rising edge
//  rst             in   1       synchronous, active-high reset
//  wb_en_in        in   1       write-back enable from EX/MEM
//  mem_r_en_in     in   1       load request
//  mem_w_en_in     in   1       store request
//  alu_result      in   ADDR_W  effective byte address, or ALU result for a non-memory op
//  rm_val          in   DATA_W  store data
//  dest_in         in   4       destination register index
//  wb_en           out  1       wb_en_in & ~freeze
//  mem_r_en        out  1       mem_r_en_in & ~freeze
//  mem_w_en        out  1       mem_w_en_in & ~freeze
//  alu_result_out  out  ADDR_W  alu_result, passed through unchanged
//  data_memory_out out  DATA_W  registered load data
//  dest            out  4       dest_in, passed through unchanged
//  freeze          out  1       stall request to upstream stages; combinational
//  addr_err        out  1       registered; high when the completed access was out of range
// BEHAVIOUR
//  Address decode
//   - Byte offset of each word: OFF = log2(DATA_W/8).
//   - Word index: idx = (alu_result - BASE_ADDR) >> OFF; the low OFF bits are ignored.
//   - In range when alu_result >= BASE_ADDR and idx < DEPTH.
//  State machine: IDLE, BUSY, DONE. cnt is a down-counter of width clog2(LATENCY+1).
//   IDLE
//    - req = mem_r_en_in | mem_w_en_in.
//    - No req: freeze=0 and all outputs pass through in the same cycle.
//    - req: freeze=1 this cycle and cnt <= LATENCY-1.
//    - Next state is DONE if LATENCY==1, otherwise BUSY.
//   BUSY
//    - freeze=1 and cnt decrements each cycle.
//    - When cnt==1: the access commits at this edge and the next state is DONE.
//   DONE
//    - freeze=0 for exactly one cycle; data_memory_out and addr_err are valid.
//    - Gated enables reach MEM/WB in this cycle. Next state is IDLE unconditionally.
//    - Upstream advances after this edge, so the same instruction never re-triggers.
//  Stall timing
//   - freeze is high for exactly LATENCY consecutive cycles per access.
//   - Result appears in cycle LATENCY, counting the arrival cycle as cycle 0.
//   - During freeze, MEM/WB captures a bubble because all three enables are gated low.
//  Commit edge (the edge entering DONE)
//   - Store in range: mem[idx] <= rm_val.
//   - Load in range: data_memory_out <= mem[idx].
//   - Store out of range: write suppressed, addr_err <= 1.
//   - Load out of range: data_memory_out <= 0, addr_err <= 1.
//   - In-range access: addr_err <= 0.
//   - A store leaves data_memory_out unchanged.
//   - mem_r_en_in and mem_w_en_in both high: treated as a store; the read is ignored.
//  Reset
//   - rst high forces state=IDLE, cnt=0, data_memory_out=0 and addr_err=0.
//   - freeze is 0 from the first cycle after rst is sampled.
//   - Reset in BUSY abandons the access: no write commits.
//   - Memory array contents are NOT cleared by reset.
//  Input stability
//   - Inputs are required to stay stable while freeze=1, because upstream is held.
//   - Behaviour under changing inputs during a stall is undefined and is not checked.
// TESTING
//  1 LATENCY=4: store 0xDEADBEEF at 1024, then load 1024
//    -> freeze high 4 cycles for each access; wb_en=0 while frozen;
//       data_memory_out=0xDEADBEEF in the load's DONE cycle.
//  2 Non-memory op, wb_en_in=1, dest_in=5, alu_result=0x1234
//    -> freeze=0; wb_en=1, dest=5, alu_result_out=0x1234 in the same cycle.
//  3 Store 0x55 at 1024+4*DEPTH, then load 1024
//    -> addr_err=1 in the store's DONE cycle; word 0 unchanged; addr_err=0 after the load.
//  4 rst asserted on cycle 2 of a BUSY store of 0xAA to 1028
//    -> freeze=0 next cycle, state IDLE; a later load of 1028 returns the prior value.
//  5 LATENCY=1: load 1032 -> freeze high exactly 1 cycle; data valid the following cycle.
//  6 Back-to-back loads at 1036 then 1040 with distinct stored data
//    -> two separate 4-cycle freeze windows separated by one DONE cycle; correct data each.

Source files
------------

// File: rtl/mem_stage_multicycle.sv
// MEM stage with a multi-cycle data memory: loads/stores freeze upstream for
// LATENCY cycles, then present one result for a single cycle toward MEM/WB.
// Ports:
//   clk, rst                      clock, sync active-high reset
//   wb_en_in/mem_r_en_in/_w_en_in enables from EX/MEM
//   alu_result, rm_val, dest_in   address/ALU value, store data, dest reg
//   wb_en/mem_r_en/mem_w_en       enables gated by freeze
//   alu_result_out, dest          pass-through
//   data_memory_out, addr_err     registered load data / range error
//   freeze                        combinational stall request upstream
module mem_stage_multicycle #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 64,
  parameter int LATENCY   = 4,
  parameter int BASE_ADDR = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rm_val,
  input  logic [3:0]        dest_in,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] data_memory_out,
  output logic [3:0]        dest,
  output logic              freeze,
  output logic              addr_err
);

  localparam int OFF = $clog2(DATA_W / 8);
  localparam int CW  = $clog2(LATENCY + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic              req;
  logic              commit;
  logic              in_rng;
  logic [ADDR_W-1:0] off_addr;
  logic [ADDR_W-1:0] widx;
  logic [IW-1:0]     idx;

  assign off_addr = alu_result - ADDR_W'(BASE_ADDR);
  assign widx     = off_addr >> OFF;
  assign idx      = widx[IW-1:0];
  assign in_rng   = (alu_result >= ADDR_W'(BASE_ADDR))
                 && (widx < ADDR_W'(DEPTH));

  assign req    = mem_r_en_in | mem_w_en_in;
  assign freeze = ((state_q == IDLE) && req)
               || (state_q == BUSY);

  // The access commits on the edge that enters DONE.
  assign commit = ((state_q == IDLE) && req && (LATENCY == 1))
               || ((state_q == BUSY) && (cnt_q == CW'(1)));

  assign wb_en           = wb_en_in & ~freeze;
  assign mem_r_en        = mem_r_en_in & ~freeze;
  assign mem_w_en        = mem_w_en_in & ~freeze;
  assign alu_result_out  = alu_result;
  assign dest            = dest_in;
  assign data_memory_out = data_q;
  assign addr_err        = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory is written only outside reset, so a reset mid-access drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        err_q <= ~in_rng;
        // Store wins when both enables are set.
        if (mem_w_en_in) begin
          if (in_rng) mem[idx] <= rm_val;
        end else begin
          data_q <= in_rng ? mem[idx] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_multicycle.sv
// Scoreboard bench for mem_stage_multicycle: LATENCY=4 and LATENCY=1 instances.
// Stimulus pushes expectations; negedge monitors pop and compare.
module tb_mem_stage_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [1:0]       wbi, rdi, wri;
  logic [1:0][31:0] alui, rmi;
  logic [1:0][3:0]  dsti;
  logic [1:0]       wbo, rdo, wro, frz, err;
  logic [1:0][31:0] aluo, dmo;
  logic [1:0][3:0]  dsto;
  logic [1:0]       nm;

  int n_cmp = 0;
  int n_bad = 0;
  int run [2];

  typedef struct {
    logic [31:0] data;
    logic        chk;
    logic        err;
    logic [2:0]  en;
    int          frz;
  } exp_t;

  typedef struct {
    logic        wb;
    logic [3:0]  dst;
    logic [31:0] alu;
  } pexp_t;

  exp_t  sb0[$];
  exp_t  sb1[$];
  pexp_t pq[$];

  mem_stage_multicycle #(.LATENCY(4)) u4 (
    .clk(clk), .rst(rst),
    .wb_en_in(wbi[0]), .mem_r_en_in(rdi[0]), .mem_w_en_in(wri[0]),
    .alu_result(alui[0]), .rm_val(rmi[0]), .dest_in(dsti[0]),
    .wb_en(wbo[0]), .mem_r_en(rdo[0]), .mem_w_en(wro[0]),
    .alu_result_out(aluo[0]), .data_memory_out(dmo[0]),
    .dest(dsto[0]), .freeze(frz[0]), .addr_err(err[0])
  );

  mem_stage_multicycle #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .wb_en_in(wbi[1]), .mem_r_en_in(rdi[1]), .mem_w_en_in(wri[1]),
    .alu_result(alui[1]), .rm_val(rmi[1]), .dest_in(dsti[1]),
    .wb_en(wbo[1]), .mem_r_en(rdo[1]), .mem_w_en(wro[1]),
    .alu_result_out(aluo[1]), .data_memory_out(dmo[1]),
    .dest(dsto[1]), .freeze(frz[1]), .addr_err(err[1])
  );

  task automatic chk(input string name, input int k,
                     input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s inst%0d got=%h want=%h @%0t",
               name, k, act, want, $time);
    end
  endtask

  task automatic mon(input int k);
    exp_t  e;
    pexp_t p;
    int    sz;
    if (rst) begin
      run[k] = 0;
      return;
    end
    if (frz[k]) begin
      run[k]++;
      chk("gate", k, {29'd0, wbo[k], rdo[k], wro[k]}, 32'd0);
    end else if (run[k] > 0) begin
      sz = (k == 0) ? sb0.size() : sb1.size();
      if (sz == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done inst%0d @%0t", k, $time);
      end else begin
        if (k == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        chk("frzlen", k, 32'(run[k]), 32'(e.frz));
        if (e.chk) chk("data", k, dmo[k], e.data);
        chk("err", k, {31'd0, err[k]}, {31'd0, e.err});
        chk("en", k, {29'd0, wbo[k], rdo[k], wro[k]}, {29'd0, e.en});
      end
      run[k] = 0;
    end else if (nm[k]) begin
      if (pq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pass inst%0d @%0t", k, $time);
      end else begin
        p = pq.pop_front();
        chk("pass_wb", k, {31'd0, wbo[k]}, {31'd0, p.wb});
        chk("pass_dst", k, {28'd0, dsto[k]}, {28'd0, p.dst});
        chk("pass_alu", k, aluo[k], p.alu);
      end
    end
  endtask

  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);

  task automatic nop(input int k);
    wbi[k] = 1'b0; rdi[k] = 1'b0; wri[k] = 1'b0;
    alui[k] = '0; rmi[k] = '0; dsti[k] = '0;
  endtask

  task automatic op(input int k, input logic r, input logic w,
                    input logic wb, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] ds,
                    input int hold);
    rdi[k] = r; wri[k] = w; wbi[k] = wb;
    alui[k] = a; rmi[k] = d; dsti[k] = ds;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  // Memory op held for LAT+1 cycles: LAT frozen cycles plus the DONE cycle.
  task automatic mop(input int k, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] xdata, input logic xerr);
    exp_t e;
    int   lat;
    lat    = (k == 0) ? 4 : 1;
    e.data = xdata;
    e.chk  = 1'b1;
    e.err  = xerr;
    e.en   = {r, r, w};
    e.frz  = lat;
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    op(k, r, w, r, a, d, 4'd3, lat + 1);
  endtask

  task automatic rst_chk();
    for (int k = 0; k < 2; k++) begin
      chk("rst_frz", k, {31'd0, frz[k]}, 32'd0);
      chk("rst_dmo", k, dmo[k], 32'd0);
      chk("rst_err", k, {31'd0, err[k]}, 32'd0);
    end
  endtask

  initial begin
    pexp_t p;
    rst = 1'b1;
    nm  = '0;
    nop(0);
    nop(1);
    repeat (2) @(posedge clk);
    #1;
    rst_chk();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Non-memory op passes straight through.
    p.wb = 1'b1; p.dst = 4'd5; p.alu = 32'h1234;
    pq.push_back(p);
    nm[0] = 1'b1;
    op(0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 4'd5, 1);
    nm[0] = 1'b0;

    // Store then load word 0.
    mop(0, 0, 1, 32'd1024, 32'hDEADBEEF, 32'h0, 1'b0);
    mop(0, 1, 0, 32'd1024, 32'h0, 32'hDEADBEEF, 1'b0);

    // Out-of-range store, word 0 untouched.
    mop(0, 0, 1, 32'd1280, 32'h55, 32'hDEADBEEF, 1'b1);
    mop(0, 1, 0, 32'd1024, 32'h0, 32'hDEADBEEF, 1'b0);

    // Last word, low address bits ignored, below-base load.
    mop(0, 0, 1, 32'd1276, 32'h600D, 32'hDEADBEEF, 1'b0);
    mop(0, 1, 0, 32'd1277, 32'h0, 32'h600D, 1'b0);
    mop(0, 1, 0, 32'd1020, 32'h0, 32'h0, 1'b1);

    // Read and write together behave as a store.
    mop(0, 1, 1, 32'd1032, 32'h77, 32'h0, 1'b0);
    mop(0, 1, 0, 32'd1032, 32'h0, 32'h77, 1'b0);

    // Reset during a busy store abandons the write.
    mop(0, 0, 1, 32'd1028, 32'h11111111, 32'h77, 1'b0);
    op(0, 1'b0, 1'b1, 1'b0, 32'd1028, 32'hAA, 4'd3, 2);
    rst = 1'b1;
    nop(0);
    @(posedge clk);
    #1;
    rst_chk();
    rst = 1'b0;
    mop(0, 1, 0, 32'd1028, 32'h0, 32'h11111111, 1'b0);

    // Back-to-back loads with distinct data.
    mop(0, 0, 1, 32'd1036, 32'hCAFEF00D, 32'h11111111, 1'b0);
    mop(0, 0, 1, 32'd1040, 32'h0BADC0DE, 32'h11111111, 1'b0);
    mop(0, 1, 0, 32'd1036, 32'h0, 32'hCAFEF00D, 1'b0);
    mop(0, 1, 0, 32'd1040, 32'h0, 32'h0BADC0DE, 1'b0);
    nop(0);

    // Single-cycle latency instance.
    mop(1, 0, 1, 32'd1032, 32'h1234ABCD, 32'h0, 1'b0);
    mop(1, 1, 0, 32'd1032, 32'h0, 32'h1234ABCD, 1'b0);
    mop(1, 1, 0, 32'd1300, 32'h0, 32'h0, 1'b1);
    nop(1);

    repeat (3) @(posedge clk);
    #1;
    chk("drain0", 0, 32'(sb0.size()), 32'd0);
    chk("drain1", 1, 32'(sb1.size()), 32'd0);
    chk("drainp", 0, 32'(pq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
